// File: rtl/mmio_uart_tx_pkg.sv
// Shared types and constants for the memory-mapped UART transmitter.
package mmio_uart_tx_pkg;

  typedef logic [3:0]  wrstb_t;
  typedef logic [15:0] div_t;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_e;

  // Register word index, taken from dmem_addr[3:2].
  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DIV    = 2'd2;
  localparam logic [1:0] REG_IRQ_EN = 2'd3;

  localparam int unsigned ST_BUSY    = 0;
  localparam int unsigned ST_FULL    = 1;
  localparam int unsigned ST_EMPTY   = 2;
  localparam int unsigned ST_OVF     = 3;
  localparam int unsigned ST_LVL_LSB = 8;

  function automatic div_t eff_div(input div_t d);
    return (d == '0) ? div_t'(1) : d;
  endfunction

endpackage

// File: rtl/mmio_uart_tx_sync_fifo.sv
// Synchronous FIFO with extra-MSB pointers; push when full and pop when empty are ignored.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign level = wr_ptr_q - rd_ptr_q;
  assign rdata = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// MMIO 8N1 UART transmitter with TX FIFO and programmable bit divisor.
// Define UART_TX_IRQ_EN to build the IRQ_EN register and the irq output.
module mmio_uart_tx
  import mmio_uart_tx_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd868
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wrdata,
  input  wrstb_t      dmem_wrstb,
  output logic [31:0] dmem_rddata,
  output logic        tx,
  output logic        irq
);

  uart_state_e state_q, state_d;
  div_t        div_q, div_d, cnt_q, cnt_d, reload;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shreg_q, shreg_d, fifo_rdata;
  logic        tx_q, tx_d, ovf_q, ovf_d;
  logic        hit, wr_en, push_req, fifo_pop, fifo_full, fifo_empty, busy, irq_en_rd;
  logic [1:0]  reg_idx;
  logic [$clog2(FIFO_DEPTH):0] fifo_level;
  logic        unused_bits;

  assign hit         = (dmem_addr[31:4] == BASE_ADDR[31:4]);
  assign reg_idx     = dmem_addr[3:2];
  assign wr_en       = hit && (dmem_wrstb != '0);
  assign push_req    = wr_en && (reg_idx == REG_DATA) && dmem_wrstb[0];
  assign busy        = (state_q != IDLE);
  assign tx          = tx_q;
  assign unused_bits = ^{dmem_addr[1:0], dmem_wrdata[31:16], dmem_wrstb[3:2]};

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_req),
    .wdata (dmem_wrdata[7:0]),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_comb begin
    div_d = div_q;
    ovf_d = ovf_q;
    if (wr_en && reg_idx == REG_DIV) begin
      if (dmem_wrstb[0]) div_d[7:0]  = dmem_wrdata[7:0];
      if (dmem_wrstb[1]) div_d[15:8] = dmem_wrdata[15:8];
    end
    if (wr_en && reg_idx == REG_STATUS && dmem_wrstb[0] && dmem_wrdata[ST_OVF]) ovf_d = 1'b0;
    // Full is sampled before the edge, so a same-cycle pop never rescues the push.
    if (push_req && fifo_full) ovf_d = 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    fifo_pop = 1'b0;
    reload   = eff_div(div_q) - 16'd1;
    case (state_q)
      IDLE: if (!fifo_empty) begin
        fifo_pop = 1'b1;
        shreg_d  = fifo_rdata;
        cnt_d    = reload;
        state_d  = START;
      end
      START: if (cnt_q == '0) begin
        cnt_d   = reload;
        bit_d   = '0;
        state_d = DATA;
      end else cnt_d = cnt_q - 16'd1;
      DATA: if (cnt_q == '0) begin
        cnt_d = reload;
        if (bit_q == 3'd7) state_d = STOP;
        else begin
          bit_d   = bit_q + 3'd1;
          shreg_d = {1'b0, shreg_q[7:1]};
        end
      end else cnt_d = cnt_q - 16'd1;
      STOP: if (cnt_q == '0) begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shreg_d  = fifo_rdata;
          cnt_d    = reload;
          state_d  = START;
        end else state_d = IDLE;
      end else cnt_d = cnt_q - 16'd1;
      default: state_d = IDLE;
    endcase
    tx_d = (state_d == START) ? 1'b0 : (state_d == DATA) ? shreg_d[0] : 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
      div_q   <= DIV_RESET;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
      div_q   <= div_d;
      ovf_q   <= ovf_d;
    end
  end

`ifdef UART_TX_IRQ_EN
  logic irq_en_q, irq_en_d, irq_q, irq_d;

  always_comb begin
    irq_en_d = irq_en_q;
    if (wr_en && reg_idx == REG_IRQ_EN && dmem_wrstb[0]) irq_en_d = dmem_wrdata[0];
    irq_d = irq_en_q && fifo_empty && !busy;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
    end
  end

  assign irq       = irq_q;
  assign irq_en_rd = irq_en_q;
`else
  assign irq       = 1'b0;
  assign irq_en_rd = 1'b0;
`endif

  always_comb begin
    dmem_rddata = '0;
    if (hit) begin
      case (reg_idx)
        REG_STATUS: begin
          dmem_rddata[ST_BUSY]                 = busy;
          dmem_rddata[ST_FULL]                 = fifo_full;
          dmem_rddata[ST_EMPTY]                = fifo_empty;
          dmem_rddata[ST_OVF]                  = ovf_q;
          dmem_rddata[ST_LVL_LSB+3:ST_LVL_LSB] = 4'(fifo_level);
        end
        REG_DIV:    dmem_rddata[15:0] = div_q;
        REG_IRQ_EN: dmem_rddata[0]    = irq_en_rd;
        default:    dmem_rddata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: expected line waveforms come from a per-byte bit-stream model.
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE     = 32'h8000_0000;
  localparam logic [31:0] A_DATA   = BASE;
  localparam logic [31:0] A_STATUS = BASE + 32'd4;
  localparam logic [31:0] A_DIV    = BASE + 32'd8;
  localparam logic [31:0] A_IRQ    = BASE + 32'd12;
  localparam int          DEPTH    = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] dmem_addr = '0;
  logic [31:0] dmem_wrdata = '0;
  logic [3:0]  dmem_wrstb = '0;
  logic [31:0] dmem_rddata;
  logic        tx, irq;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] pend_q[$];

  always #5 clk = ~clk;

  mmio_uart_tx #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH), .DIV_RESET(16'd868)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .dmem_addr   (dmem_addr),
    .dmem_wrdata (dmem_wrdata),
    .dmem_wrstb  (dmem_wrstb),
    .dmem_rddata (dmem_rddata),
    .tx          (tx),
    .irq         (irq)
  );

  function automatic logic [31:0] status_word(input bit busy, input bit full, input bit empty,
                                              input bit ovf, input int lvl);
    logic [3:0] l;
    l = 4'(lvl);
    return {20'h0, l, 4'h0, ovf, empty, full, busy};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    dmem_addr   = addr;
    dmem_wrdata = data;
    dmem_wrstb  = strb;
    tick();
    dmem_wrstb  = '0;
  endtask

  task automatic do_reset();
    dmem_wrstb = '0;
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Sends pend_q at the given divisor; checks tx and busy every cycle against the ideal 8N1 stream.
  task automatic send_and_check(input logic [15:0] div, input string tag);
    bit   exp[$];
    int   d, n;
    logic eb;
    n = pend_q.size();
    d = (div == 16'd0) ? 1 : int'(div);
    exp.push_back(1'b1);
    foreach (pend_q[i]) begin
      repeat (d) exp.push_back(1'b0);
      for (int b = 0; b < 8; b++) repeat (d) exp.push_back(pend_q[i][b]);
      repeat (d) exp.push_back(1'b1);
    end
    bus_write(A_DIV, {16'h0, div}, 4'b0011);
    foreach (pend_q[i]) bus_write(A_DATA, {24'h0, pend_q[i]}, 4'b0001);
    dmem_addr = A_STATUS;
    #1;
    for (int k = n - 1; k <= exp.size(); k++) begin
      if (k < exp.size()) begin
        vectors++;
        if (tx !== exp[k]) begin
          miscompares++;
          $display("FAIL %s tx k=%0d got %b exp %b", tag, k, tx, exp[k]);
        end
        eb = (k >= 1);
        vectors++;
        if (dmem_rddata[0] !== eb) begin
          miscompares++;
          $display("FAIL %s busy k=%0d got %b exp %b", tag, k, dmem_rddata[0], eb);
        end
      end else begin
        vectors++;
        if (tx !== 1'b1 || dmem_rddata !== 32'h4) begin
          miscompares++;
          $display("FAIL %s idle_end got tx=%b st=%h exp tx=1 st=00000004", tag, tx, dmem_rddata);
        end
      end
      tick();
    end
    pend_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    vectors++;
    if (tx !== 1'b1 || irq !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_lines got tx=%b irq=%b exp tx=1 irq=0", tx, irq);
    end
    dmem_addr = A_STATUS; #1;
    vectors++;
    if (dmem_rddata !== 32'h4) begin
      miscompares++;
      $display("FAIL reset_status got %h exp 00000004", dmem_rddata);
    end
    dmem_addr = A_DIV; #1;
    vectors++;
    if (dmem_rddata !== 32'd868) begin
      miscompares++;
      $display("FAIL reset_div got %0d exp 868", dmem_rddata);
    end
    dmem_addr = A_DATA; #1;
    vectors++;
    if (dmem_rddata !== 32'h0) begin
      miscompares++;
      $display("FAIL data_read got %h exp 0", dmem_rddata);
    end
    dmem_addr = A_IRQ; #1;
    vectors++;
    if (dmem_rddata !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_irq_en got %h exp 0", dmem_rddata);
    end
    dmem_addr = BASE + 32'h14; #1;
    vectors++;
    if (dmem_rddata !== 32'h0) begin
      miscompares++;
      $display("FAIL out_of_window got %h exp 0", dmem_rddata);
    end
  endtask

  task automatic test_frame();
    pend_q.push_back(8'h55);
    send_and_check(16'd4, "frame55");
    for (int i = 0; i < 4; i++) begin
      pend_q.push_back(8'($urandom));
      send_and_check(16'($urandom_range(0, 5)), "frame_rand");
    end
  endtask

  task automatic test_back_to_back();
    pend_q.push_back(8'hA0);
    pend_q.push_back(8'h0F);
    send_and_check(16'd2, "b2b");
    repeat (3) pend_q.push_back(8'($urandom));
    send_and_check(16'($urandom_range(1, 3)), "b2b_rand");
  endtask

  task automatic test_overflow();
    int  lvl;
    bit  ovf, popped;
    bit  full_pre;
    logic [31:0] exp_st;
    do_reset();
    bus_write(A_DIV, 32'd100, 4'b0011);
    lvl = 0; ovf = 0; popped = 0;
    for (int i = 0; i < 10; i++) begin
      full_pre = (lvl == DEPTH);
      if (i > 0 && !popped) begin
        lvl--;
        popped = 1;
      end
      if (full_pre) ovf = 1;
      else lvl++;
      bus_write(A_DATA, 32'($urandom), 4'b0001);
      if (i >= 8) begin
        dmem_addr = A_STATUS; #1;
        exp_st = status_word(1, lvl == DEPTH, lvl == 0, ovf, lvl);
        vectors++;
        if (dmem_rddata !== exp_st) begin
          miscompares++;
          $display("FAIL ovf_status w=%0d got %h exp %h", i + 1, dmem_rddata, exp_st);
        end
      end
    end
    bus_write(A_STATUS, 32'h0, 4'b0001);
    dmem_addr = A_STATUS; #1;
    exp_st = status_word(1, lvl == DEPTH, lvl == 0, ovf, lvl);
    vectors++;
    if (dmem_rddata !== exp_st) begin
      miscompares++;
      $display("FAIL ovf_keep got %h exp %h", dmem_rddata, exp_st);
    end
    bus_write(A_STATUS, 32'h8, 4'b0001);
    dmem_addr = A_STATUS; #1;
    exp_st = status_word(1, lvl == DEPTH, lvl == 0, 0, lvl);
    vectors++;
    if (dmem_rddata !== exp_st) begin
      miscompares++;
      $display("FAIL ovf_clear got %h exp %h", dmem_rddata, exp_st);
    end
    do_reset();
  endtask

  task automatic test_reset_midframe();
    bus_write(A_DIV, 32'd4, 4'b0011);
    bus_write(A_DATA, 32'h00, 4'b0001);
    repeat (17) tick();
    vectors++;
    if (tx !== 1'b0) begin
      miscompares++;
      $display("FAIL midframe_bit3 got %b exp 0", tx);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (tx !== 1'b1) begin
      miscompares++;
      $display("FAIL midframe_rst_tx got %b exp 1", tx);
    end
    dmem_addr = A_STATUS; #1;
    vectors++;
    if (dmem_rddata !== 32'h4) begin
      miscompares++;
      $display("FAIL midframe_rst_status got %h exp 00000004", dmem_rddata);
    end
    dmem_addr = A_DIV; #1;
    vectors++;
    if (dmem_rddata !== 32'd868 || irq !== 1'b0) begin
      miscompares++;
      $display("FAIL midframe_rst_div got %0d irq=%b exp 868 irq=0", dmem_rddata, irq);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_div_change();
    bit exp[$];
    logic [7:0] b;
    b = 8'($urandom);
    exp.push_back(1'b1);
    repeat (4) exp.push_back(1'b0);
    for (int i = 0; i < 8; i++) repeat ((i < 3) ? 4 : 8) exp.push_back(b[i]);
    repeat (8) exp.push_back(1'b1);
    bus_write(A_DIV, 32'd4, 4'b0011);
    bus_write(A_DATA, {24'h0, b}, 4'b0001);
    for (int k = 0; k <= exp.size(); k++) begin
      if (k == 14) begin
        dmem_addr = A_DIV; dmem_wrdata = 32'd8; dmem_wrstb = 4'b0011;
      end
      vectors++;
      if (k < exp.size()) begin
        if (tx !== exp[k]) begin
          miscompares++;
          $display("FAIL divchg tx k=%0d got %b exp %b", k, tx, exp[k]);
        end
      end else if (tx !== 1'b1) begin
        miscompares++;
        $display("FAIL divchg idle got %b exp 1", tx);
      end
      tick();
      dmem_wrstb = '0;
    end
    dmem_addr = A_DIV; #1;
    vectors++;
    if (dmem_rddata !== 32'd8) begin
      miscompares++;
      $display("FAIL divchg_readback got %0d exp 8", dmem_rddata);
    end
  endtask

  task automatic test_irq();
    logic e;
`ifdef UART_TX_IRQ_EN
    bus_write(A_IRQ, 32'h1, 4'b0001);
    vectors++;
    if (irq !== 1'b0) begin
      miscompares++;
      $display("FAIL irq_latency got %b exp 0", irq);
    end
    tick();
    dmem_addr = A_IRQ; #1;
    vectors++;
    if (irq !== 1'b1 || dmem_rddata !== 32'h1) begin
      miscompares++;
      $display("FAIL irq_idle got irq=%b en=%h exp irq=1 en=1", irq, dmem_rddata);
    end
    bus_write(A_DIV, 32'd2, 4'b0011);
    bus_write(A_DATA, 32'($urandom), 4'b0001);
    for (int k = 0; k <= 23; k++) begin
      e = (k == 0) || (k >= 22);
      vectors++;
      if (irq !== e) begin
        miscompares++;
        $display("FAIL irq_frame k=%0d got %b exp %b", k, irq, e);
      end
      tick();
    end
    bus_write(A_IRQ, 32'h0, 4'b0001);
`else
    bus_write(A_IRQ, 32'h1, 4'b0001);
    dmem_addr = A_IRQ; #1;
    vectors++;
    if (dmem_rddata !== 32'h0) begin
      miscompares++;
      $display("FAIL irq_en_absent got %h exp 0", dmem_rddata);
    end
    bus_write(A_DIV, 32'd1, 4'b0011);
    bus_write(A_DATA, 32'($urandom), 4'b0001);
    for (int k = 0; k < 14; k++) begin
      e = 1'b0;
      vectors++;
      if (irq !== e) begin
        miscompares++;
        $display("FAIL irq_tied k=%0d got %b exp 0", k, irq);
      end
      tick();
    end
`endif
  endtask

  initial begin
    test_reset();
    test_frame();
    test_back_to_back();
    test_div_change();
    test_overflow();
    test_reset_midframe();
    test_irq();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
